ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Parametrised instruction prefetch queue between the instruction-memory fetch stage and decode. It buffers up to DEPTH fetched instruction words with their PCs behind a valid/ready handshake on each side. It supports a synchronous flush for branch redirects. It also pre-decodes the register fields of the two oldest entries, so hazard logic sees the next instruction's sources and the next two destinations one stage early.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); pointer width.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous queue clear (branch/jump redirect).
- wr_valid  input  1  fetch stage offers a word.
- wr_ready  output  1  queue accepts a word this cycle.
- wr_pc  input  32  PC of offered word.
- wr_instr  input  32  offered instruction word.
- rd_valid  output  1  head entry present.
- rd_ready  input  1  decode consumes head this cycle.
- rd_pc  output  32  PC of head entry.
- rd_instr  output  32  head instruction word.
- rs_next  output  5  rs field of head.
- rs_next_vld  output  1  head reads rs.
- rt_next  output  5  rt field of head.
- rt_next_vld  output  1  head reads rt.
- rd1  output  5  destination register of head.
- rd1_vld  output  1  head writes a register.
- rd2  output  5  destination register of entry behind head.
- rd2_vld  output  1  second entry present and writes a register.
- count  output  PTR_W+1  number of valid entries, 0..DEPTH.

## Operation
- Circular buffer of DEPTH {pc, instr} entries, with write pointer, read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- wr_ready = (count != DEPTH). There is no pass-through when full, even if rd_ready is high.
- Push occurs when wr_valid && wr_ready. Pop occurs when rd_valid && rd_ready.
- Simultaneous push and pop: both pointers advance and count is unchanged.
- rd_valid = (count != 0).
- rd_pc and rd_instr show the head entry. They read as 0 when empty.
- Flush: on the next edge, pointers and count go to 0. Flush overrides a push or pop in the same cycle, so the offered word is dropped.
- Pre-decode is combinational and applied identically to the head and second entries:
  - R-type (instr[31:26]==0): reads rs and rt; destination is instr[15:11].
  - Immediate (instr[31:29]!=0): reads rs only; destination is instr[20:16].
  - Other opcodes (001xxx excluded above; 000001–000111 jump/branch class): no register reads, no destination.
- When a field is not used, its value output is 0 and its _vld is 0. Outputs are never high-impedance.
- Destination 0 (r0) still reports its _vld per the class rules. Hazard logic masks r0.
- rd2 and rd2_vld come from entry read_ptr+1, with wrap. Both are 0 when count < 2.

## Timing
- Reset: count=0, pointers=0. Storage is not cleared. With rd_valid=0, wr_ready=1 and all decode outputs and _vld=0, rd_pc and rd_instr read 0.
- Push-to-read latency is 1 cycle. A word accepted at edge N appears on rd_* after edge N when the queue was empty. There is no same-cycle bypass.
- wr_ready, rd_valid and count are functions of registered state only. They have no combinational dependence on wr_valid or rd_ready.
- Decode outputs change in the same cycle as rd_instr.
- Full throughput: one push and one pop per cycle is sustained whenever 0 < count < DEPTH.
- rst asserted mid-operation empties the queue immediately (asynchronously). Words in flight are lost.

## Test plan
- Reset, then push 0x012A4020 (add $8,$9,$10) at PC 0x0: one cycle later rd_valid=1, rs_next=9, rt_next=10, rd1=8, all _vld=1, rd2_vld=0, count=1.
- Push addi 0x2128FFFF followed by j 0x08000010 without popping: rd1=8 (rt), rs_next=9, rt_next_vld=0, rd2_vld=0 (jump class). Pop once: head decode shows all _vld=0.
- Fill DEPTH=4 entries with no pops: wr_ready=0, count=4. A further wr_valid is not accepted. Then assert rd_ready and wr_valid together for 8 cycles: ordering is preserved across pointer wrap.
- Steady stream with count=2, push and pop every cycle: count stays 2. rd_pc advances by 4 per cycle when fed sequential PCs.
- Assert flush together with wr_valid on a 3-entry queue: the next cycle has count=0, rd_valid=0, and the flushed-cycle word is absent.
- Assert rst asynchronously mid-stream, between edges: rd_valid and all decode _vld drop before the next edge, and count=0.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between fetch and decode.
// Circular buffer of {pc, instr} entries with valid/ready on both sides,
// synchronous flush for redirects, and register-field pre-decode of the
// two oldest entries so hazard logic sees them one stage early.
module ifetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_pc,
    input  logic [31:0]      wr_instr,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_pc,
    output logic [31:0]      rd_instr,
    output logic [4:0]       rs_next,
    output logic             rs_next_vld,
    output logic [4:0]       rt_next,
    output logic             rt_next_vld,
    output logic [4:0]       rd1,
    output logic             rd1_vld,
    output logic [4:0]       rd2,
    output logic             rd2_vld,
    output logic [PTR_W:0]   count
);

    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_second;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;
    logic             has_two;

    // Source-register pre-decode: returns {rs_vld, rs, rt_vld, rt}.
    // R-type reads rs and rt, immediate class reads rs only, jump/branch
    // class (opcodes 1..7) reads nothing. Unused fields read as zero.
    function automatic logic [11:0] src_fields(
        input logic [5:0] op,
        input logic [4:0] rs_f,
        input logic [4:0] rt_f,
        input logic       present
    );
        logic [11:0] r;
        r = '0;
        if (present) begin
            if (op == 6'd0) begin
                r = {1'b1, rs_f, 1'b1, rt_f};
            end else if (op[5:3] != 3'd0) begin
                r = {1'b1, rs_f, 1'b0, 5'd0};
            end
        end
        return r;
    endfunction

    // Destination pre-decode: returns {vld, reg}. r0 is still reported
    // valid; masking it is left to the hazard logic.
    function automatic logic [5:0] dst_field(
        input logic [5:0] op,
        input logic [4:0] rt_f,
        input logic [4:0] rd_f,
        input logic       present
    );
        logic [5:0] r;
        r = '0;
        if (present) begin
            if (op == 6'd0) begin
                r = {1'b1, rd_f};
            end else if (op[5:3] != 3'd0) begin
                r = {1'b1, rt_f};
            end
        end
        return r;
    endfunction

    // Handshake status depends only on the registered occupancy.
    assign wr_ready = (cnt != FULL_CNT);
    assign rd_valid = (cnt != '0);
    assign count    = cnt;
    assign push     = wr_valid && wr_ready;
    assign pop      = rd_valid && rd_ready;
    assign has_two  = (cnt >= TWO_CNT);

    assign rd_ptr_second = rd_ptr + PTR_W'(1);

    // Entry storage; not reset, contents are qualified by the occupancy.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr]    <= wr_pc;
            instr_mem[wr_ptr] <= wr_instr;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head entry view, forced to zero while the queue is empty.
    assign rd_pc    = rd_valid ? pc_mem[rd_ptr]    : 32'd0;
    assign rd_instr = rd_valid ? instr_mem[rd_ptr] : 32'd0;

    // Head pre-decode: sources and destination.
    assign {rs_next_vld, rs_next, rt_next_vld, rt_next} =
        src_fields(instr_mem[rd_ptr][31:26], instr_mem[rd_ptr][25:21],
                   instr_mem[rd_ptr][20:16], rd_valid);

    assign {rd1_vld, rd1} =
        dst_field(instr_mem[rd_ptr][31:26], instr_mem[rd_ptr][20:16],
                  instr_mem[rd_ptr][15:11], rd_valid);

    // Second-oldest entry destination, only when two entries are held.
    assign {rd2_vld, rd2} =
        dst_field(instr_mem[rd_ptr_second][31:26], instr_mem[rd_ptr_second][20:16],
                  instr_mem[rd_ptr_second][15:11], has_two);

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: fixed vector table, directed multi-cycle
// sequences and randomized traffic against a queue-based reference model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_pc;
    logic [31:0] wr_instr;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic [4:0]  rs_next;
    logic        rs_next_vld;
    logic [4:0]  rt_next;
    logic        rt_next_vld;
    logic [4:0]  rd1;
    logic        rd1_vld;
    logic [4:0]  rd2;
    logic        rd2_vld;
    logic [2:0]  count;

    ifetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pc(wr_pc), .wr_instr(wr_instr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_pc(rd_pc), .rd_instr(rd_instr),
        .rs_next(rs_next), .rs_next_vld(rs_next_vld),
        .rt_next(rt_next), .rt_next_vld(rt_next_vld),
        .rd1(rd1), .rd1_vld(rd1_vld), .rd2(rd2), .rd2_vld(rd2_vld),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr_ready;
        logic        rd_valid;
        logic [2:0]  count;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rs;
        logic        rs_v;
        logic [4:0]  rt;
        logic        rt_v;
        logic [4:0]  rd1;
        logic        rd1_v;
        logic [4:0]  rd2;
        logic        rd2_v;
    } out_t;

    typedef struct packed {
        logic        fl;
        logic        wv;
        logic        rr;
        logic [31:0] pc;
        logic [31:0] instr;
        out_t        exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct packed {
        logic [4:0] rs;
        logic       rs_v;
        logic [4:0] rt;
        logic       rt_v;
        logic [4:0] d;
        logic       d_v;
    } dec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ent_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference decode from the instruction-class rules.
    function automatic dec_t ref_decode(input logic [31:0] ins, input bit present);
        dec_t        r;
        int unsigned op;
        int unsigned f_rs;
        int unsigned f_rt;
        int unsigned f_rd;
        r    = '0;
        op   = ins >> 26;
        f_rs = (ins >> 21) % 32;
        f_rt = (ins >> 16) % 32;
        f_rd = (ins >> 11) % 32;
        if (present) begin
            if (op == 0) begin
                r.rs = 5'(f_rs); r.rs_v = 1'b1;
                r.rt = 5'(f_rt); r.rt_v = 1'b1;
                r.d  = 5'(f_rd); r.d_v  = 1'b1;
            end else if (op >= 8) begin
                r.rs = 5'(f_rs); r.rs_v = 1'b1;
                r.d  = 5'(f_rt); r.d_v  = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic out_t model_out();
        out_t o;
        dec_t h;
        dec_t s;
        int   n;
        n = q.size();
        o = '0;
        h = '0;
        s = '0;
        o.wr_ready = (n != DEPTH);
        o.rd_valid = (n != 0);
        o.count    = 3'(n);
        if (n > 0) begin
            o.pc    = q[0].pc;
            o.instr = q[0].instr;
            h       = ref_decode(q[0].instr, 1'b1);
        end
        if (n > 1) s = ref_decode(q[1].instr, 1'b1);
        o.rs = h.rs;  o.rs_v  = h.rs_v;
        o.rt = h.rt;  o.rt_v  = h.rt_v;
        o.rd1 = h.d;  o.rd1_v = h.d_v;
        o.rd2 = s.d;  o.rd2_v = s.d_v;
        return o;
    endfunction

    task automatic check_all(input string tag, input out_t e);
        chk({tag, ".wr_ready"}, 32'(wr_ready),    32'(e.wr_ready));
        chk({tag, ".rd_valid"}, 32'(rd_valid),    32'(e.rd_valid));
        chk({tag, ".count"},    32'(count),       32'(e.count));
        chk({tag, ".rd_pc"},    rd_pc,            e.pc);
        chk({tag, ".rd_instr"}, rd_instr,         e.instr);
        chk({tag, ".rs"},       32'(rs_next),     32'(e.rs));
        chk({tag, ".rs_vld"},   32'(rs_next_vld), 32'(e.rs_v));
        chk({tag, ".rt"},       32'(rt_next),     32'(e.rt));
        chk({tag, ".rt_vld"},   32'(rt_next_vld), 32'(e.rt_v));
        chk({tag, ".rd1"},      32'(rd1),         32'(e.rd1));
        chk({tag, ".rd1_vld"},  32'(rd1_vld),     32'(e.rd1_v));
        chk({tag, ".rd2"},      32'(rd2),         32'(e.rd2));
        chk({tag, ".rd2_vld"},  32'(rd2_vld),     32'(e.rd2_v));
    endtask

    // One model-tracked cycle: drive at negedge, update model at posedge,
    // compare at the following negedge.
    task automatic mcycle(input logic fl, input logic wv, input logic [31:0] pc,
                          input logic [31:0] ins, input logic rr, input string tag,
                          output bit acc);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        flush    = fl;
        wr_valid = wv;
        wr_pc    = pc;
        wr_instr = ins;
        rd_ready = rr;
        do_push  = wv && (q.size() < DEPTH);
        do_pop   = rr && (q.size() > 0);
        acc      = do_push && !fl;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.pc    = pc;
                e.instr = ins;
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_all(tag, model_out());
    endtask

    function automatic vec_t row(
        input int fl, input int wv, input int rr,
        input int unsigned pc, input int unsigned ins,
        input int wrr, input int rdv, input int cnt,
        input int unsigned epc, input int unsigned eins,
        input int rs, input int rsv, input int rt, input int rtv,
        input int d1, input int d1v, input int d2, input int d2v);
        vec_t v;
        v.fl = 1'(fl); v.wv = 1'(wv); v.rr = 1'(rr);
        v.pc = pc; v.instr = ins;
        v.exp.wr_ready = 1'(wrr);
        v.exp.rd_valid = 1'(rdv);
        v.exp.count    = 3'(cnt);
        v.exp.pc       = epc;
        v.exp.instr    = eins;
        v.exp.rs  = 5'(rs);  v.exp.rs_v  = 1'(rsv);
        v.exp.rt  = 5'(rt);  v.exp.rt_v  = 1'(rtv);
        v.exp.rd1 = 5'(d1);  v.exp.rd1_v = 1'(d1v);
        v.exp.rd2 = 5'(d2);  v.exp.rd2_v = 1'(d2v);
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        out_t        r0;
        bit          acc;
        logic [31:0] npc;
        logic [31:0] prev_pc;
        logic [31:0] ins;
        int          sel;

        //                 fl wv rr pc            instr          rdy v cnt epc           einstr         rs rsv rt rtv d1 d1v d2 d2v
        tbl[0]  = row(0, 1, 0, 32'h0000_0000, 32'h012A_4020, 1, 1, 1, 32'h0000_0000, 32'h012A_4020, 9, 1, 10, 1, 8, 1, 0, 0);
        tbl[1]  = row(0, 1, 0, 32'h0000_0004, 32'h2128_FFFF, 1, 1, 2, 32'h0000_0000, 32'h012A_4020, 9, 1, 10, 1, 8, 1, 8, 1);
        tbl[2]  = row(0, 1, 0, 32'h0000_0008, 32'h0800_0010, 1, 1, 3, 32'h0000_0000, 32'h012A_4020, 9, 1, 10, 1, 8, 1, 8, 1);
        tbl[3]  = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 1, 2, 32'h0000_0004, 32'h2128_FFFF, 9, 1, 0, 0, 8, 1, 0, 0);
        tbl[4]  = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 1, 1, 32'h0000_0008, 32'h0800_0010, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = row(0, 1, 1, 32'h0000_000C, 32'h8D28_0004, 1, 1, 1, 32'h0000_000C, 32'h8D28_0004, 9, 1, 0, 0, 8, 1, 0, 0);
        tbl[6]  = row(1, 1, 1, 32'h0000_0010, 32'h012A_4020, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = row(0, 0, 0, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = row(0, 1, 0, 32'h0000_0020, 32'h0000_0020, 1, 1, 1, 32'h0000_0020, 32'h0000_0020, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[9]  = row(0, 1, 0, 32'h0000_0024, 32'h1100_0003, 1, 1, 2, 32'h0000_0020, 32'h0000_0020, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[10] = row(0, 1, 0, 32'h0000_0028, 32'h3508_00FF, 1, 1, 3, 32'h0000_0020, 32'h0000_0020, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[11] = row(0, 1, 0, 32'h0000_002C, 32'hAD09_0000, 0, 1, 4, 32'h0000_0020, 32'h0000_0020, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[12] = row(0, 1, 0, 32'h0000_0030, 32'h012A_4020, 0, 1, 4, 32'h0000_0020, 32'h0000_0020, 0, 1, 0, 1, 0, 1, 0, 0);
        tbl[13] = row(0, 1, 1, 32'h0000_0030, 32'h012A_4020, 1, 1, 3, 32'h0000_0024, 32'h1100_0003, 0, 0, 0, 0, 0, 0, 8, 1);
        tbl[14] = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 1, 2, 32'h0000_0028, 32'h3508_00FF, 8, 1, 0, 0, 8, 1, 9, 1);
        tbl[15] = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 1, 1, 32'h0000_002C, 32'hAD09_0000, 8, 1, 0, 0, 9, 1, 0, 0);
        tbl[16] = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = row(0, 0, 1, 32'h0000_0000, 32'h0000_0000, 1, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 0);

        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_pc    = 32'd0;
        wr_instr = 32'd0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        r0 = '0;
        r0.wr_ready = 1'b1;
        check_all("reset", r0);

        // Fixed vectors: state after each edge.
        for (int i = 0; i < 18; i++) begin
            flush    = tbl[i].fl;
            wr_valid = tbl[i].wv;
            rd_ready = tbl[i].rr;
            wr_pc    = tbl[i].pc;
            wr_instr = tbl[i].instr;
            @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), tbl[i].exp);
        end
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;

        // Fill to full, then an offered word that must be refused.
        npc = 32'h0000_1000;
        for (int k = 0; k < 5; k++) begin
            mcycle(1'b0, 1'b1, npc, $urandom, 1'b0, $sformatf("fill%0d", k), acc);
            if (acc) npc = npc + 32'd4;
        end
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(wr_ready), 32'd0);

        // Push and pop together across pointer wrap.
        for (int k = 0; k < 8; k++) begin
            mcycle(1'b0, 1'b1, npc, $urandom, 1'b1, $sformatf("wrap%0d", k), acc);
            if (acc) npc = npc + 32'd4;
        end

        // Settle at two entries, then stream with sequential PCs.
        mcycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "drain", acc);
        for (int k = 0; k < 10; k++) begin
            prev_pc = q[0].pc;
            mcycle(1'b0, 1'b1, npc, $urandom, 1'b1, $sformatf("steady%0d", k), acc);
            if (acc) npc = npc + 32'd4;
            chk("steady_count", 32'(count), 32'd2);
            chk("steady_pc", rd_pc, prev_pc + 32'd4);
        end

        // Flush on a three-entry queue while a word is offered.
        mcycle(1'b0, 1'b1, npc, $urandom, 1'b0, "pre_flush", acc);
        mcycle(1'b1, 1'b1, 32'hDEAD_0000, 32'h012A_4020, 1'b1, "flush", acc);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(rd_valid), 32'd0);
        mcycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "post_flush", acc);

        // Asynchronous reset between edges with entries held.
        for (int k = 0; k < 3; k++) begin
            mcycle(1'b0, 1'b1, 32'h0000_2000 + 32'(k * 4), 32'h012A_4020, 1'b0,
                   $sformatf("prerst%0d", k), acc);
        end
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("arst_count",   32'(count),       32'd0);
        chk("arst_valid",   32'(rd_valid),    32'd0);
        chk("arst_ready",   32'(wr_ready),    32'd1);
        chk("arst_rs_vld",  32'(rs_next_vld), 32'd0);
        chk("arst_rt_vld",  32'(rt_next_vld), 32'd0);
        chk("arst_rd1_vld", 32'(rd1_vld),     32'd0);
        chk("arst_rd2_vld", 32'(rd2_vld),     32'd0);
        #1 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check_all("post_arst", model_out());

        // Randomized traffic against the model.
        for (int k = 0; k < 500; k++) begin
            ins = $urandom;
            sel = $urandom_range(0, 3);
            if (sel == 0) ins[31:26] = 6'd0;
            else if (sel == 1) ins[31:26] = 6'($urandom_range(1, 7));
            mcycle(1'($urandom_range(0, 31) == 0),
                   1'($urandom_range(0, 99) < 70),
                   $urandom & 32'hFFFF_FFFC, ins,
                   1'($urandom_range(0, 99) < 60),
                   $sformatf("rand%0d", k), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
